// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, memory wait-state stalls and EX redirects,
// including discarding a wrong-path fetch. Define HAZARD_CTRL_PERF_EN for the stall/flush counters.
module hazard_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [4:0]      ex_rd,
    input  logic            ex_mem_read,
    input  logic            ex_redirect,
    input  logic [XLEN-1:0] ex_target,
    input  logic            imem_req,
    input  logic            imem_resp,
    input  logic            dmem_req,
    input  logic            dmem_resp,
    output logic            pc_load,
    output logic            if_id_load,
    output logic            id_ex_load,
    output logic            ex_mem_load,
    output logic            mem_wb_load,
    output logic            if_id_flush,
    output logic            id_ex_flush,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     stall_cycles,
    output logic [31:0]     flush_count
);

    typedef enum logic {
        RUN  = 1'b0,
        DROP = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] redirect_q, redirect_d;
    logic            resp_seen_q, resp_seen_d;

    logic mem_stall;
    logic if_stall;
    logic load_use;

    assign mem_stall = dmem_req & ~dmem_resp;
    assign if_stall  = imem_req & ~imem_resp;
    assign load_use  = ex_mem_read && (ex_rd != 5'd0) &&
                       ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    // NOTE: every output and next-state value gets a default first so no path infers a latch.
    always_comb begin
        state_d        = state_q;
        redirect_d     = redirect_q;
        resp_seen_d    = resp_seen_q;
        pc_load        = 1'b1;
        if_id_load     = 1'b1;
        id_ex_load     = 1'b1;
        ex_mem_load    = 1'b1;
        mem_wb_load    = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        if (rst) begin
            // Load NOPs everywhere while reset is held.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (mem_stall) begin
                        pc_load     = 1'b0;
                        if_id_load  = 1'b0;
                        id_ex_load  = 1'b0;
                        ex_mem_load = 1'b0;
                        mem_wb_load = 1'b0;
                    end else if (ex_redirect && !if_stall) begin
                        if_id_flush    = 1'b1;
                        id_ex_flush    = 1'b1;
                        redirect_valid = 1'b1;
                        redirect_pc    = ex_target;
                    end else if (ex_redirect && if_stall) begin
                        redirect_d  = ex_target;
                        resp_seen_d = 1'b0;
                        state_d     = DROP;
                        pc_load     = 1'b0;
                        if_id_load  = 1'b0;
                        id_ex_flush = 1'b1;
                    end else if (load_use || if_stall) begin
                        pc_load     = 1'b0;
                        if_id_load  = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
                DROP: begin
                    redirect_pc = redirect_q;
                    if (mem_stall) begin
                        pc_load     = 1'b0;
                        if_id_load  = 1'b0;
                        id_ex_load  = 1'b0;
                        ex_mem_load = 1'b0;
                        mem_wb_load = 1'b0;
                        if (imem_resp) begin
                            resp_seen_d = 1'b1;
                        end
                    end else if (imem_resp || resp_seen_q) begin
                        // Wrong-path fetch has returned: take the saved redirect now.
                        redirect_valid = 1'b1;
                        if_id_flush    = 1'b1;
                        id_ex_flush    = 1'b1;
                        state_d        = RUN;
                        resp_seen_d    = 1'b0;
                    end else begin
                        pc_load     = 1'b0;
                        if_id_load  = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            redirect_q  <= '0;
            resp_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            redirect_q  <= redirect_d;
            resp_seen_q <= resp_seen_d;
        end
    end

`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (!pc_load) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (redirect_valid) begin
                flush_count_q <= flush_count_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl; control outputs are compared as a packed vector
// {pc, if_id, id_ex, ex_mem, mem_wb loads, if_id_flush, id_ex_flush, redirect_valid}.
module tb_hazard_ctrl;

    localparam int XLEN = 32;

    localparam logic [7:0] C_RESET = 8'b11111_11_0;
    localparam logic [7:0] C_RUN   = 8'b11111_00_0;
    localparam logic [7:0] C_STALL = 8'b00111_01_0;
    localparam logic [7:0] C_MEMST = 8'b00000_00_0;
    localparam logic [7:0] C_REDIR = 8'b11111_11_1;

    logic            clk = 1'b0;
    logic            rst;
    logic [4:0]      id_rs1, id_rs2, ex_rd;
    logic            id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect;
    logic [XLEN-1:0] ex_target;
    logic            imem_req, imem_resp, dmem_req, dmem_resp;
    logic            pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
    logic            if_id_flush, id_ex_flush, redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [31:0]     stall_cycles, flush_count;

    int checks = 0;
    int fails  = 0;

    logic [7:0] ctl;
    assign ctl = {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
                  if_id_flush, id_ex_flush, redirect_valid};

    always #5 clk = ~clk;

    hazard_ctrl #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .ex_target(ex_target),
        .imem_req(imem_req), .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
        .pc_load(pc_load), .if_id_load(if_id_load), .id_ex_load(id_ex_load),
        .ex_mem_load(ex_mem_load), .mem_wb_load(mem_wb_load),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = 5'd0; ex_mem_read = 1'b0; ex_redirect = 1'b0; ex_target = '0;
        imem_req = 1'b0; imem_resp = 1'b0; dmem_req = 1'b0; dmem_resp = 1'b0;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        ex_redirect = 1'b1;
        ex_target   = 32'hDEAD_BEE0;
        settle();
        checks++;
        if (ctl !== C_RESET) begin
            fails++; $display("FAIL reset_ctl: got %b expected %b", ctl, C_RESET);
        end
        checks++;
        if (redirect_pc !== 32'h0) begin
            fails++; $display("FAIL reset_pc: got %h expected %h", redirect_pc, 32'h0);
        end
        next_cycle();
        checks++;
        if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
            fails++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cycles, flush_count);
        end
        rst = 1'b0;
        idle();
        settle();
        checks++;
        if (ctl !== C_RUN) begin
            fails++; $display("FAIL reset_to_run: got %b expected %b", ctl, C_RUN);
        end
        next_cycle();
    endtask

    task automatic test_load_use();
        // lw x5 in EX, add x6,x5,x1 in ID
        idle();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_use_rs1 = 1'b1; id_rs1 = 5'd5; id_rs2 = 5'd1; id_use_rs2 = 1'b1;
        settle();
        checks++;
        if (ctl !== C_STALL) begin
            fails++; $display("FAIL load_use_rs1: got %b expected %b", ctl, C_STALL);
        end
        next_cycle();
        idle();
        settle();
        checks++;
        if (ctl !== C_RUN) begin
            fails++; $display("FAIL load_use_release: got %b expected %b", ctl, C_RUN);
        end
        next_cycle();
        ex_mem_read = 1'b1; ex_rd = 5'd9; id_use_rs1 = 1'b1; id_rs1 = 5'd3; id_use_rs2 = 1'b1; id_rs2 = 5'd9;
        settle();
        checks++;
        if (ctl !== C_STALL) begin
            fails++; $display("FAIL load_use_rs2: got %b expected %b", ctl, C_STALL);
        end
        next_cycle();
        idle();
        imem_req = 1'b1;
        settle();
        checks++;
        if (ctl !== C_STALL) begin
            fails++; $display("FAIL if_stall: got %b expected %b", ctl, C_STALL);
        end
        next_cycle();
        idle();
        settle();
        checks++;
        if (ctl !== C_RUN) begin
            fails++; $display("FAIL if_stall_release: got %b expected %b", ctl, C_RUN);
        end
        next_cycle();
    endtask

    task automatic test_no_hazard();
        idle();
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_use_rs1 = 1'b1; id_rs1 = 5'd0;
        settle();
        checks++;
        if (ctl !== C_RUN) begin
            fails++; $display("FAIL x0_no_stall: got %b expected %b", ctl, C_RUN);
        end
        next_cycle();
        ex_rd = 5'd5; id_use_rs1 = 1'b0; id_rs1 = 5'd5;
        settle();
        checks++;
        if (ctl !== C_RUN) begin
            fails++; $display("FAIL unused_rs1_no_stall: got %b expected %b", ctl, C_RUN);
        end
        next_cycle();
        // load-use plus redirect resolves as a redirect
        id_use_rs1 = 1'b1; ex_redirect = 1'b1; ex_target = 32'h0000_0A40;
        settle();
        checks++;
        if (ctl !== C_REDIR || redirect_pc !== 32'h0000_0A40) begin
            fails++; $display("FAIL load_use_vs_redirect: got %b/%h expected %b/%h",
                              ctl, redirect_pc, C_REDIR, 32'h0000_0A40);
        end
        next_cycle();
        idle();
    endtask

    task automatic test_mem_stall();
        idle();
        ex_redirect = 1'b1; ex_target = 32'h0000_0200; dmem_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            checks++;
            if (ctl !== C_MEMST) begin
                fails++; $display("FAIL mem_stall_cycle%0d: got %b expected %b", i, ctl, C_MEMST);
            end
            next_cycle();
        end
        dmem_resp = 1'b1;
        settle();
        checks++;
        if (ctl !== C_REDIR || redirect_pc !== 32'h0000_0200) begin
            fails++; $display("FAIL mem_stall_redirect: got %b/%h expected %b/%h",
                              ctl, redirect_pc, C_REDIR, 32'h0000_0200);
        end
        next_cycle();
        idle();
    endtask

    // Redirect under an outstanding fetch; leaves counters at stall+2, flush+1.
    task automatic test_drop();
        idle();
        ex_redirect = 1'b1; ex_target = 32'h0000_0100; imem_req = 1'b1;
        settle();
        checks++;
        if (ctl !== C_STALL) begin
            fails++; $display("FAIL drop_enter: got %b expected %b", ctl, C_STALL);
        end
        next_cycle();
        ex_target = 32'h0000_0300;
        settle();
        checks++;
        if (ctl !== C_STALL || redirect_pc !== 32'h0000_0100) begin
            fails++; $display("FAIL drop_wait: got %b/%h expected %b/%h",
                              ctl, redirect_pc, C_STALL, 32'h0000_0100);
        end
        next_cycle();
        ex_redirect = 1'b0; imem_resp = 1'b1;
        settle();
        checks++;
        if (ctl !== C_REDIR || redirect_pc !== 32'h0000_0100) begin
            fails++; $display("FAIL drop_complete: got %b/%h expected %b/%h",
                              ctl, redirect_pc, C_REDIR, 32'h0000_0100);
        end
        next_cycle();
        idle();
        settle();
        checks++;
        if (ctl !== C_RUN) begin
            fails++; $display("FAIL drop_back_to_run: got %b expected %b", ctl, C_RUN);
        end
        next_cycle();
    endtask

    task automatic test_redirect_with_resp();
        idle();
        ex_redirect = 1'b1; ex_target = 32'h0000_0500; imem_req = 1'b1; imem_resp = 1'b1;
        settle();
        checks++;
        if (ctl !== C_REDIR || redirect_pc !== 32'h0000_0500) begin
            fails++; $display("FAIL resp_and_redirect: got %b/%h expected %b/%h",
                              ctl, redirect_pc, C_REDIR, 32'h0000_0500);
        end
        next_cycle();
        idle();
        settle();
        checks++;
        if (ctl !== C_RUN) begin
            fails++; $display("FAIL resp_and_redirect_no_drop: got %b expected %b", ctl, C_RUN);
        end
        next_cycle();
    endtask

    task automatic test_drop_resp_seen();
        idle();
        ex_redirect = 1'b1; ex_target = 32'h0000_0400; imem_req = 1'b1;
        settle();
        checks++;
        if (ctl !== C_STALL) begin
            fails++; $display("FAIL seen_enter: got %b expected %b", ctl, C_STALL);
        end
        next_cycle();
        ex_redirect = 1'b0; imem_resp = 1'b1; dmem_req = 1'b1;
        settle();
        checks++;
        if (ctl !== C_MEMST || redirect_pc !== 32'h0000_0400) begin
            fails++; $display("FAIL seen_mem_stall: got %b/%h expected %b/%h",
                              ctl, redirect_pc, C_MEMST, 32'h0000_0400);
        end
        next_cycle();
        imem_req = 1'b0; imem_resp = 1'b0; dmem_resp = 1'b1;
        settle();
        checks++;
        if (ctl !== C_REDIR || redirect_pc !== 32'h0000_0400) begin
            fails++; $display("FAIL seen_complete: got %b/%h expected %b/%h",
                              ctl, redirect_pc, C_REDIR, 32'h0000_0400);
        end
        next_cycle();
        idle();
        settle();
        checks++;
        if (ctl !== C_RUN) begin
            fails++; $display("FAIL seen_back_to_run: got %b expected %b", ctl, C_RUN);
        end
        next_cycle();
    endtask

    task automatic test_perf();
        logic [31:0] exp_stall;
        logic [31:0] exp_flush;
        rst = 1'b1;
        idle();
        next_cycle();
        checks++;
        if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
            fails++; $display("FAIL perf_cleared: got %0d/%0d expected 0/0", stall_cycles, flush_count);
        end
        rst = 1'b0;
        test_drop();
`ifdef HAZARD_CTRL_PERF_EN
        exp_stall = 32'd2;
        exp_flush = 32'd1;
`else
        exp_stall = 32'd0;
        exp_flush = 32'd0;
`endif
        checks++;
        if (stall_cycles !== exp_stall || flush_count !== exp_flush) begin
            fails++; $display("FAIL perf_counts: got %0d/%0d expected %0d/%0d",
                              stall_cycles, flush_count, exp_stall, exp_flush);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #1;
        test_reset();
        test_load_use();
        test_no_hazard();
        test_mem_stall();
        test_drop();
        test_redirect_with_resp();
        test_drop_resp_seen();
        test_perf();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
